// File: rtl/fetch_sequencer_pkg.sv
// fetch_seq_pkg
// Shared definitions for the fetch sequencer: FSM state encodings, next-PC
// source encodings, vector-table slot indices and the default vector-table
// base address. Imported by the interface, the trap_pending sub-module and
// the fetch_sequencer top.
// Ports: none (package).
package fetch_seq_pkg;

  // FSM states. 2'b11 is unused and recovers to LOOKUP of the reset slot.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_TRAP    = 2'b01,
    ST_LOOKUP  = 2'b10,
    ST_ILLEGAL = 2'b11
  } fetch_state_e;

  // Next-PC mux select seen by the PC register.
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_VEC = 2'b10,
    PCSRC_EPC = 2'b11
  } pc_src_e;

  typedef logic [1:0] slot_t;

  // Vector-table slots; the slot index doubles as the trap cause code.
  localparam slot_t SLOT_RESET = 2'd0;
  localparam slot_t SLOT_EXPT1 = 2'd1;
  localparam slot_t SLOT_EXPT2 = 2'd2;
  localparam slot_t SLOT_INT   = 2'd3;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0000;

  // Byte address of vector-table slot s (one 32-bit word per slot).
  function automatic logic [31:0] slot_addr(input logic [31:0] base, input slot_t s);
    return base + {28'd0, s, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the event inputs and fetch-control outputs of the fetch sequencer.
// Modports:
//   master - the pipeline side: drives int_req, expt1, expt2, eret, stall,
//            branch_taken, pc; observes the control outputs.
//   slave  - the fetch sequencer: consumes the events and drives pc_src,
//            pc_we, imem_addr_sel, vec_addr, flush, epc, int_ack, cause, state.
interface fetch_sequencer_if;
  import fetch_seq_pkg::*;

  logic         int_req;
  logic         expt1;
  logic         expt2;
  logic         eret;
  logic         stall;
  logic         branch_taken;
  logic [31:0]  pc;

  pc_src_e      pc_src;
  logic         pc_we;
  logic         imem_addr_sel;
  logic [31:0]  vec_addr;
  logic         flush;
  logic [31:0]  epc;
  logic         int_ack;
  logic [1:0]   cause;
  fetch_state_e state;

  modport master (
    output int_req, expt1, expt2, eret, stall, branch_taken, pc,
    input  pc_src, pc_we, imem_addr_sel, vec_addr, flush, epc, int_ack, cause, state
  );

  modport slave (
    input  int_req, expt1, expt2, eret, stall, branch_taken, pc,
    output pc_src, pc_we, imem_addr_sel, vec_addr, flush, epc, int_ack, cause, state
  );

endinterface

// File: rtl/fetch_sequencer_trap_pending.sv
// trap_pending
// Holds the pending flags for the two exception pulses and resolves the
// fixed-priority trap source (expt1 > expt2 > interrupt).
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   expt1_i/expt2_i - exception pulses
//   int_req_i       - level interrupt request
//   in_handler_i    - masks the interrupt while a handler runs
//   clr_expt1_i/clr_expt2_i - clear the flag of the source being taken
//   trap_valid_o    - some trap source is present
//   trap_slot_o     - vector slot of the winning source (SLOT_RESET if none)
module trap_pending (
  input  logic                clk,
  input  logic                rst,
  input  logic                expt1_i,
  input  logic                expt2_i,
  input  logic                int_req_i,
  input  logic                in_handler_i,
  input  logic                clr_expt1_i,
  input  logic                clr_expt2_i,
  output logic                trap_valid_o,
  output fetch_seq_pkg::slot_t trap_slot_o
);
  import fetch_seq_pkg::*;

  logic pend1_q, pend1_d;
  logic pend2_q, pend2_d;
  logic expt1_src, expt2_src, int_src;

  // A pulse counts the cycle it arrives and afterwards through its flag.
  // Exceptions are never masked; the interrupt is masked inside a handler.
  always_comb begin
    expt1_src = expt1_i | pend1_q;
    expt2_src = expt2_i | pend2_q;
    int_src   = int_req_i & ~in_handler_i;
  end

  // Fixed-priority encoder.
  always_comb begin
    trap_valid_o = expt1_src | expt2_src | int_src;
    trap_slot_o  = SLOT_RESET;
    if (expt1_src) begin
      trap_slot_o = SLOT_EXPT1;
    end else if (expt2_src) begin
      trap_slot_o = SLOT_EXPT2;
    end else if (int_src) begin
      trap_slot_o = SLOT_INT;
    end
  end

  // Every pulse is remembered unless its source is the one being taken
  // this cycle. That covers pulses arriving in TRAP/LOOKUP and a losing
  // exception in a RUN cycle that takes another trap.
  always_comb begin
    pend1_d = (pend1_q | expt1_i) & ~clr_expt1_i;
    pend2_d = (pend2_q | expt2_i) & ~clr_expt2_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
    end else begin
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns all fetch-stage control: next-PC source selection, the reset-vector
// lookup after reset, and trap entry (EPC capture, flush, vector lookup)
// for exceptions and interrupts.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset
//   bus  - fetch_sequencer_if.slave: int_req, expt1, expt2, eret, stall,
//          branch_taken, pc in; pc_src, pc_we, imem_addr_sel, vec_addr,
//          flush, epc, int_ack, cause, state out
// Parameter:
//   VEC_BASE - byte address of the vector table (slot n at VEC_BASE + 4n)
// Build option:
//   FETCH_SEQ_CAUSE_EN - when defined, cause is a register loaded with the
//   taken slot on trap entry; otherwise cause is tied to 2'b00.
module fetch_sequencer #(
  parameter logic [31:0] VEC_BASE = fetch_seq_pkg::VEC_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.slave   bus
);
  import fetch_seq_pkg::*;

  fetch_state_e state_q, state_d;
  slot_t        slot_q, slot_d;
  logic [31:0]  epc_q, epc_d;
  logic         in_handler_q, in_handler_d;

  logic         trap_valid;
  slot_t        trap_slot;
  logic         take_trap;
  logic         clr_expt1, clr_expt2;

  pc_src_e      pc_src;
  logic         pc_we;
  logic         flush;
  logic         imem_addr_sel;
  logic         int_ack;

  trap_pending u_trap_pending (
    .clk          (clk),
    .rst          (rst),
    .expt1_i      (bus.expt1),
    .expt2_i      (bus.expt2),
    .int_req_i    (bus.int_req),
    .in_handler_i (in_handler_q),
    .clr_expt1_i  (clr_expt1),
    .clr_expt2_i  (clr_expt2),
    .trap_valid_o (trap_valid),
    .trap_slot_o  (trap_slot)
  );

  // A trap is only accepted in RUN; elsewhere sources just accumulate.
  always_comb begin
    take_trap = (state_q == ST_RUN) && trap_valid;
    clr_expt1 = take_trap && (trap_slot == SLOT_EXPT1);
    clr_expt2 = take_trap && (trap_slot == SLOT_EXPT2);
  end

  // Next-state and output logic. In RUN the trap check comes first so it
  // overrides stall, branch and eret in the same cycle.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    epc_d         = epc_q;
    in_handler_d  = in_handler_q;
    pc_src        = PCSRC_SEQ;
    pc_we         = 1'b0;
    flush         = 1'b0;
    imem_addr_sel = 1'b0;
    int_ack       = 1'b0;

    case (state_q)
      ST_LOOKUP: begin
        imem_addr_sel = 1'b1;
        pc_src        = PCSRC_VEC;
        pc_we         = 1'b1;
        flush         = 1'b1;
        state_d       = ST_RUN;
      end

      ST_RUN: begin
        if (trap_valid) begin
          flush        = 1'b1;
          epc_d        = bus.pc;
          slot_d       = trap_slot;
          in_handler_d = 1'b1;
          int_ack      = (trap_slot == SLOT_INT);
          state_d      = ST_TRAP;
        end else if (bus.eret && !bus.stall) begin
          pc_src       = PCSRC_EPC;
          pc_we        = 1'b1;
          flush        = 1'b1;
          in_handler_d = 1'b0;
        end else if (bus.stall) begin
          pc_we = 1'b0;
        end else if (bus.branch_taken) begin
          pc_src = PCSRC_BR;
          pc_we  = 1'b1;
          flush  = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end

      ST_TRAP: begin
        flush   = 1'b1;
        state_d = ST_LOOKUP;
      end

      // The unused encoding restarts from the reset vector.
      default: begin
        flush   = 1'b1;
        slot_d  = SLOT_RESET;
        state_d = ST_LOOKUP;
      end
    endcase
  end

  // Control state register; reset starts with the reset-vector lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOOKUP;
      slot_q       <= SLOT_RESET;
      epc_q        <= 32'd0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      epc_q        <= epc_d;
      in_handler_q <= in_handler_d;
    end
  end

`ifdef FETCH_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  // Slot index equals the cause code; held until the next trap entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_q <= 2'b00;
    end else if (take_trap) begin
      cause_q <= trap_slot;
    end
  end

  assign bus.cause = cause_q;
`else
  assign bus.cause = 2'b00;
`endif

  assign bus.pc_src        = pc_src;
  assign bus.pc_we         = pc_we;
  assign bus.flush         = flush;
  assign bus.imem_addr_sel = imem_addr_sel;
  assign bus.int_ack       = int_ack;
  assign bus.vec_addr      = slot_addr(VEC_BASE, slot_q);
  assign bus.epc           = epc_q;
  assign bus.state         = state_q;

endmodule
